// File: rtl/spi_lcd_pkg.sv
// rtl/spi_lcd_pkg.sv - opcodes, FSM states and pixel width shared by the SPI LCD receiver
package spi_lcd_pkg;

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_RASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;

  localparam int RGB565_W = 16;

  typedef enum logic [1:0] {
    ST_SKIP,
    ST_CASET_ARG,
    ST_RASET_ARG,
    ST_RAMWR
  } state_e;

endpackage

// File: rtl/spi_lcd_shift.sv
// rtl/spi_lcd_shift.sv - SPI mode-0 input synchronizers and byte deserializer
module spi_lcd_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  input  logic       dc_i,
  output logic [7:0] byte_o,
  output logic       dc_o,
  output logic       stb_o
);

  // sclk_q[0]/[1] are the synchronizer, sclk_q[2] the previous sample for edge detect
  logic [2:0] sclk_q;
  logic [1:0] mosi_q, cs_q, dc_q;
  logic       rise_q, bit_q, bdc_q;
  logic [2:0] cnt_q;
  logic [6:0] sr_q;
  logic [7:0] byte_q;
  logic       dco_q, stb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q   <= 2'b11;
      dc_q   <= '0;
      rise_q <= 1'b0;
      bit_q  <= 1'b0;
      bdc_q  <= 1'b0;
      cnt_q  <= '0;
      sr_q   <= '0;
      byte_q <= '0;
      dco_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      mosi_q <= {mosi_q[0], mosi_i};
      cs_q   <= {cs_q[0], cs_n_i};
      dc_q   <= {dc_q[0], dc_i};
      rise_q <= sclk_q[1] & ~sclk_q[2] & ~cs_q[1];
      bit_q  <= mosi_q[1];
      bdc_q  <= dc_q[1];
      stb_q  <= 1'b0;
      if (cs_q[1]) begin
        cnt_q <= '0;
      end else if (rise_q) begin
        sr_q  <= {sr_q[5:0], bit_q};
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_q <= {sr_q, bit_q};
          dco_q  <= bdc_q;
          stb_q  <= 1'b1;
        end
      end
    end
  end

  assign byte_o = byte_q;
  assign dc_o   = dco_q;
  assign stb_o  = stb_q;

endmodule

// File: rtl/spi_lcd_rx.sv
// rtl/spi_lcd_rx.sv - SPI LCD panel-side receiver: command FSM, address window, RGB565 pixel writes (option: SPI_LCD_RX_RAMWRC_EN)
module spi_lcd_rx #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  input  logic              spi_dc,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] pix_x,
  output logic [ADDR_W-1:0] pix_y,
  output logic [15:0]       pix_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte
);
  import spi_lcd_pkg::*;

  logic [7:0] byte_w;
  logic       dc_w, stb_w;

  spi_lcd_shift u_shift (
    .clk    (clk),
    .rst    (rst),
    .sclk_i (spi_sclk),
    .mosi_i (spi_mosi),
    .cs_n_i (spi_cs_n),
    .dc_i   (spi_dc),
    .byte_o (byte_w),
    .dc_o   (dc_w),
    .stb_o  (stb_w)
  );

  state_e              state_q;
  logic                phase_q;
  logic [1:0]          arg_idx_q;
  logic [7:0]          sh0_q, sh1_q, sh2_q, hi_q;
  logic [ADDR_W-1:0]   xs_q, xe_q, ys_q, ye_q, x_q, y_q;
  logic                pix_valid_q, cmd_valid_q;
  logic [ADDR_W-1:0]   pix_x_q, pix_y_q;
  logic [RGB565_W-1:0] pix_data_q;
  logic [7:0]          cmd_byte_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SKIP;
      phase_q     <= 1'b0;
      arg_idx_q   <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      hi_q        <= '0;
      xs_q        <= '0;
      ys_q        <= '0;
      xe_q        <= '1;
      ye_q        <= '1;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_data_q  <= '0;
      cmd_byte_q  <= '0;
    end else begin
      pix_valid_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      if (stb_w && !dc_w) begin
        cmd_valid_q <= 1'b1;
        cmd_byte_q  <= byte_w;
        phase_q     <= 1'b0;
        arg_idx_q   <= '0;
        case (byte_w)
          CMD_CASET: state_q <= ST_CASET_ARG;
          CMD_RASET: state_q <= ST_RASET_ARG;
          CMD_RAMWR: begin
            state_q <= ST_RAMWR;
            x_q     <= xs_q;
            y_q     <= ys_q;
          end
`ifdef SPI_LCD_RX_RAMWRC_EN
          CMD_RAMWRC: state_q <= ST_RAMWR;
`endif
          default: state_q <= ST_SKIP;
        endcase
      end else if (stb_w) begin
        case (state_q)
          ST_CASET_ARG, ST_RASET_ARG: begin
            arg_idx_q <= arg_idx_q + 2'd1;
            case (arg_idx_q)
              2'd0: sh0_q <= byte_w;
              2'd1: sh1_q <= byte_w;
              2'd2: sh2_q <= byte_w;
              default: begin
                // start and end commit together so a truncated argument list leaves the window intact
                if (state_q == ST_CASET_ARG) begin
                  xs_q <= ADDR_W'({sh0_q, sh1_q});
                  xe_q <= ADDR_W'({sh2_q, byte_w});
                end else begin
                  ys_q <= ADDR_W'({sh0_q, sh1_q});
                  ye_q <= ADDR_W'({sh2_q, byte_w});
                end
                state_q <= ST_SKIP;
              end
            endcase
          end
          ST_RAMWR: begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
              hi_q <= byte_w;
            end else begin
              pix_valid_q <= 1'b1;
              pix_x_q     <= x_q;
              pix_y_q     <= y_q;
              pix_data_q  <= {hi_q, byte_w};
              if (x_q == xe_q) begin
                x_q <= xs_q;
                y_q <= (y_q == ye_q) ? ys_q : y_q + 1'b1;
              end else begin
                x_q <= x_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_data  = pix_data_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// tb/tb_spi_lcd_rx.sv - self-checking bench for spi_lcd_rx against a pixel-stream reference model
module tb_spi_lcd_rx;
  import spi_lcd_pkg::*;

  localparam int AW = 8;
  localparam int W  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, sclk, mosi, cs_n, dc;
  logic          pix_valid, cmd_valid;
  logic [AW-1:0] pix_x, pix_y;
  logic [15:0]   pix_data;
  logic [7:0]    cmd_byte;

  always #5 clk = ~clk;

  spi_lcd_rx #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (sclk),
    .spi_mosi  (mosi),
    .spi_cs_n  (cs_n),
    .spi_dc    (dc),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] obs_pix[$], exp_pix[$];
  logic [7:0]  obs_cmd[$], exp_cmd[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) obs_pix.push_back({pix_x, pix_y, pix_data});
      if (cmd_valid) obs_cmd.push_back(cmd_byte);
    end
  end

  // reference model: window as integers, cursor advanced with modulo arithmetic
  int m_mode, m_hi, m_xs, m_xe, m_ys, m_ye, m_x, m_y;
  int m_args[$];

  function automatic void model_reset();
    m_mode = -1; m_hi = -1;
    m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = W - 1;
    m_x = 0; m_y = 0;
    m_args.delete();
  endfunction

  function automatic void model_byte(input bit d, input int b);
    logic [31:0] p;
    if (!d) begin
      exp_cmd.push_back(8'(b));
      m_args.delete();
      m_hi = -1;
      m_mode = b;
      if (b == int'(CMD_RAMWR)) begin
        m_x = m_xs; m_y = m_ys;
      end
`ifdef SPI_LCD_RX_RAMWRC_EN
      if (b == int'(CMD_RAMWRC)) m_mode = int'(CMD_RAMWR);
`endif
    end else if (m_mode == int'(CMD_CASET) || m_mode == int'(CMD_RASET)) begin
      m_args.push_back(b);
      if (m_args.size() == 4) begin
        if (m_mode == int'(CMD_CASET)) begin
          m_xs = (m_args[0] * 256 + m_args[1]) % W;
          m_xe = (m_args[2] * 256 + m_args[3]) % W;
        end else begin
          m_ys = (m_args[0] * 256 + m_args[1]) % W;
          m_ye = (m_args[2] * 256 + m_args[3]) % W;
        end
        m_mode = -1;
      end
    end else if (m_mode == int'(CMD_RAMWR)) begin
      if (m_hi < 0) begin
        m_hi = b;
      end else begin
        p = {8'(m_x), 8'(m_y), 16'(m_hi * 256 + b)};
        exp_pix.push_back(p);
        m_hi = -1;
        if (m_x == m_xe) begin
          m_x = m_xs;
          m_y = (m_y == m_ye) ? m_ys : (m_y + 1) % W;
        end else begin
          m_x = (m_x + 1) % W;
        end
      end
    end
  endfunction

  task automatic spi_bits(input int n, input logic [7:0] b, input bit d);
    cs_n = 1'b0;
    dc   = d;
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0; mosi = b[i]; #40;
      sclk = 1'b1; #40;
    end
    sclk = 1'b0;
  endtask

  task automatic send(input bit d, input int b);
    spi_bits(8, 8'(b), d);
    model_byte(d, b);
  endtask

  task automatic send_pix(input int p);
    send(1'b1, (p >> 8) & 8'hFF);
    send(1'b1, p & 8'hFF);
  endtask

  task automatic cs_release();
    #40 cs_n = 1'b1;
    #200;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic check_flush(input string tag);
    int n;
    #400;
    chk({tag, " pix_count"}, obs_pix.size(), exp_pix.size());
    n = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s pix[%0d]", tag, i), obs_pix[i], exp_pix[i]);
    chk({tag, " cmd_count"}, obs_cmd.size(), exp_cmd.size());
    n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s cmd[%0d]", tag, i), 32'(obs_cmd[i]), 32'(exp_cmd[i]));
    obs_pix.delete(); exp_pix.delete();
    obs_cmd.delete(); exp_cmd.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, " cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, " pix_x"},     32'(pix_x),     32'd0);
    chk({tag, " pix_y"},     32'(pix_y),     32'd0);
    chk({tag, " pix_data"},  32'(pix_data),  32'd0);
    chk({tag, " cmd_byte"},  32'(cmd_byte),  32'd0);
  endtask

  initial begin
    int xs, xe, ys, ye, npix;
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; dc = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");
    repeat (20) @(negedge clk);
    chk_outputs_zero("idle");
    check_flush("idle");

    send(1'b0, CMD_RAMWR); send_pix(16'hF800);
    cs_release();
    check_flush("first_pixel");

    send(1'b0, CMD_CASET); send(1, 8'h00); send(1, 8'h02); send(1, 8'h00); send(1, 8'h03);
    send(1'b0, CMD_RASET); send(1, 8'h00); send(1, 8'h05); send(1, 8'h00); send(1, 8'h06);
    send(1'b0, CMD_RAMWR);
    send_pix(16'hF800); send_pix(16'h07E0); send_pix(16'h001F); send_pix(16'h1234); send_pix(16'hFFFF);
    cs_release();
    check_flush("window");

    // cursor now at (3,5); a 5-bit fragment must not disturb it
    spi_bits(5, 8'hA5, 1'b1);
    cs_release();
    send(1'b1, 8'h07); send(1'b1, 8'hE0);
    cs_release();
    check_flush("partial_byte");

    send(1'b0, 8'h11); send(1, 8'hAA); send(1, 8'hBB);
    cs_release();
    check_flush("unknown_cmd");

    send(1'b0, CMD_RAMWR); send(1, 8'h12);
    send(1'b0, CMD_RAMWR); send_pix(16'h001F);
    cs_release();
    check_flush("phase_reset");

    send(1'b0, CMD_RAMWR); send_pix(16'hABCD); send_pix(16'h0101);
    send(1'b0, CMD_RAMWRC); send_pix(16'h5A5A);
    cs_release();
    check_flush("ramwr_continue");

    for (int r = 0; r < 8; r++) begin
      xs = $urandom_range(0, W - 1);
      xe = (xs + $urandom_range(0, 4)) % W;
      ys = $urandom_range(0, W - 1);
      ye = (ys + $urandom_range(0, 3)) % W;
      if (r == 3) begin xe = xs; xs = (xe + W - 2) % W; end
      send(1'b0, CMD_CASET);
      send(1, $urandom_range(0, 255)); send(1, xs);
      send(1, $urandom_range(0, 255)); send(1, xe);
      send(1'b0, CMD_RASET);
      send(1, $urandom_range(0, 255)); send(1, ys);
      if ($urandom_range(0, 3) != 0) begin
        send(1, $urandom_range(0, 255)); send(1, ye);
      end
      send(1'b0, CMD_RAMWR);
      npix = $urandom_range(1, 12);
      for (int k = 0; k < npix; k++) begin
        send_pix($urandom_range(0, 16'hFFFF));
        if ($urandom_range(0, 4) == 0) cs_release();
      end
      if ($urandom_range(0, 2) == 0) begin
        send(1'b0, 8'h29); send(1, $urandom_range(0, 255));
      end
      cs_release();
      check_flush($sformatf("random%0d", r));
    end

    spi_bits(4, 8'hFF, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cs_n = 1'b1; sclk = 1'b0;
    model_reset();
    obs_pix.delete(); obs_cmd.delete(); exp_pix.delete(); exp_cmd.delete();
    @(negedge clk);
    chk_outputs_zero("mid_reset");
    #200;
    send(1'b0, CMD_RAMWR); send_pix(16'hC3C3); send_pix(16'h3C3C);
    cs_release();
    check_flush("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
